bus_drive_arbiter: RTL and testbench
====================================

Name: bus_drive_arbiter

Overview:
- Drive-side controller placed directly upstream of the per-bit tristate net resolvers on a shared bus.
- Arbitrates among N bus drivers with round-robin priority and generates their active-low output enables.
- Registers each driver's data lane and inserts break-before-make dead time between owners, so no two enables ever overlap.
- Monitors the resolved net's noe feedback and raises a sticky error on contention or a floating bus.

Parameters:
- N_DRV, 2, number of drivers sharing the bus (2..8).
- WIDTH, 8, bus width in bits; one resolver instance per bit consumes one bit of every lane.
- DEAD_CYCLES, 1, turnaround cycles with all enables high after an owner releases; legal range 1..15.
- MAX_HOLD, 0, maximum DRIVE cycles before preemption when another driver requests; 0 = unlimited.

Ports:
- i_clk  input  1  clock; everything updates on the rising edge.
- i_nrst  input  1  synchronous active-low reset.
- i_req  input  N_DRV  per-driver bus request, level-sensitive.
- i_data  input  N_DRV*WIDTH  per-driver data; lane k is bits [k*WIDTH +: WIDTH].
- i_net_noe  input  1  resolved-net noe feedback; 0 = exactly one driver enabled.
- i_err_clr  input  1  clears o_err.
- o_noe  output  N_DRV  per-driver output enable, active low; registered.
- o_data  output  N_DRV*WIDTH  per-driver registered data lanes.
- o_gnt  output  N_DRV  one-hot grant; equals ~o_noe.
- o_busy  output  1  high in DRIVE or TURNAROUND.
- o_err  output  1  sticky protocol/contention error.

Behaviour:
- Reset (i_nrst=0 at an edge):
  - o_noe all 1; o_gnt 0; o_data all 1; o_busy 0; o_err 0.
  - State IDLE; rr pointer 0; hold and dead counters 0.
  - Reset mid-DRIVE releases the bus at that same edge with no dead time.
- States: IDLE, DRIVE, TURNAROUND.
- IDLE:
  - If any i_req is high, the winner is the first requester at or after the rr pointer, wrapping modulo N_DRV.
  - At the next edge: state becomes DRIVE, o_noe[w]=0, rr pointer = (w+1) mod N_DRV, hold counter = 1.
  - Latency from req sampled high in IDLE to enable low is one edge.
- DRIVE:
  - Owner w keeps the bus while i_req[w]=1.
  - Hold counter increments every cycle and saturates at 15-bit max.
  - Release conditions, whichever comes first:
    - i_req[w]=0;
    - MAX_HOLD!=0, hold counter == MAX_HOLD, and any other i_req is high.
  - On release, at the next edge: o_noe all 1, state TURNAROUND, dead counter = DEAD_CYCLES.
- TURNAROUND:
  - Dead counter decrements each cycle; when it reaches 0, state goes to IDLE.
  - Requests are ignored here.
  - Between owners, all enables stay high for exactly DEAD_CYCLES+1 cycles (TURNAROUND plus the IDLE arbitration cycle).
- Data path:
  - Each edge in DRIVE: o_data lane w <= i_data lane w. All other lanes <= all ones (the net's undriven default).
  - Outside DRIVE: all lanes all ones.
  - o_data and o_noe always change on the same edge.
- Error check, evaluated each cycle on registered state:
  - DRIVE with i_net_noe!=0 is an error (net floating or contended).
  - IDLE or TURNAROUND with i_net_noe==0 is an error (foreign driver).
  - An error sets o_err at the next edge; o_err then stays 1.
  - i_err_clr clears o_err at the next edge. If clear and a new error coincide, set wins.
- Requests that change during arbitration are sampled once, in the IDLE cycle.
- A requester that drops and reasserts is re-arbitrated normally.
- o_noe never has more than one 0 bit. o_busy = (state != IDLE).

Test Plan:
- Reset then idle: i_nrst=0 for 2 cycles, then i_req=0 -> o_noe=2'b11, o_data all 8'hFF, o_busy=0, o_err=0.
- Single grant: i_req=2'b10, i_data lane1=8'hA5 -> one edge later o_noe=2'b01, o_gnt=2'b10, o_data lane1=8'hA5, lane0=8'hFF; drop req -> o_noe=2'b11 for exactly 2 cycles (DEAD_CYCLES=1) with no overlap.
- Round-robin fairness: i_req=2'b11 held constantly with MAX_HOLD=4 -> grants alternate 0,1,0,...; each owner holds 4 cycles, separated by 2 all-high cycles.
- Preemption disabled: MAX_HOLD=0, i_req=2'b11 -> driver 0 holds indefinitely until i_req[0]=0, then driver 1 is granted after the dead time.
- Contention/float error: force i_net_noe=1 during DRIVE -> o_err=1 next edge; pulse i_err_clr -> o_err=0; force i_net_noe=0 in IDLE -> o_err=1 again.
- Reset mid-operation: assert i_nrst=0 during DRIVE of driver 1 -> at that edge o_noe=2'b11 and state IDLE; after release, with i_req=2'b11 driver 0 is granted first (rr pointer 0).

Source files
------------

// File: rtl/bus_drive_arbiter_if.sv
// Bundle of request/data/feedback inputs and enable/data/status outputs
// exchanged between the bus drivers and the drive-side arbiter.
interface bus_drive_arbiter_if #(
    parameter int N_DRV = 2,
    parameter int WIDTH = 8
);
    logic [N_DRV-1:0]       i_req;
    logic [N_DRV*WIDTH-1:0] i_data;
    logic                   i_net_noe;
    logic                   i_err_clr;
    logic [N_DRV-1:0]       o_noe;
    logic [N_DRV*WIDTH-1:0] o_data;
    logic [N_DRV-1:0]       o_gnt;
    logic                   o_busy;
    logic                   o_err;

    modport master (
        output i_req, i_data, i_net_noe, i_err_clr,
        input  o_noe, o_data, o_gnt, o_busy, o_err
    );

    modport slave (
        input  i_req, i_data, i_net_noe, i_err_clr,
        output o_noe, o_data, o_gnt, o_busy, o_err
    );
endinterface

// File: rtl/bus_drive_arbiter.sv
// Round-robin drive-side arbiter for a shared tristate bus. Generates
// registered active-low enables and data lanes, enforces break-before-make
// dead time between owners and flags contention / floating-net conditions.
module bus_drive_arbiter #(
    parameter int N_DRV       = 2,
    parameter int WIDTH       = 8,
    parameter int DEAD_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    bus_drive_arbiter_if.slave bus
);
    localparam int IDX_W = (N_DRV > 1) ? $clog2(N_DRV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam logic [14:0]            HOLD_SAT   = 15'h7FFF;
    localparam logic [14:0]            MAX_HOLD_C = 15'(MAX_HOLD);
    localparam logic [3:0]             DEAD_C     = 4'(DEAD_CYCLES);
    localparam logic [N_DRV-1:0]       ONE_HOT0   = N_DRV'(1);
    localparam logic [N_DRV-1:0]       ALL_HIGH   = {N_DRV{1'b1}};
    localparam logic [N_DRV*WIDTH-1:0] DATA_IDLE  = {(N_DRV*WIDTH){1'b1}};
    localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(N_DRV - 1);

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [14:0]            hold_q, hold_d;
    logic [3:0]             dead_q, dead_d;
    logic [N_DRV-1:0]       noe_q, noe_d;
    logic [N_DRV*WIDTH-1:0] data_q, data_d;
    logic                   err_q, err_d;

    logic                   win_vld_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic                   others_req_s;
    logic                   release_s;
    logic                   err_s;

    // Wrap an index in 0..2*N_DRV-2 back into 0..N_DRV-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= N_DRV) ? IDX_W'(v - N_DRV) : IDX_W'(v);
    endfunction

    // Round-robin search: first requester at or after the rr pointer.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
        for (int i = 0; i < N_DRV; i++) begin
            if (!win_vld_s && bus.i_req[wrap_idx(int'(rr_q) + i)]) begin
                win_vld_s = 1'b1;
                win_idx_s = wrap_idx(int'(rr_q) + i);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Release decision for the current owner: request dropped or hold limit hit under competition.
    always_comb begin
        others_req_s = |(bus.i_req & ~(ONE_HOT0 << owner_q));
        release_s    = !bus.i_req[owner_q] ||
                       ((MAX_HOLD != 0) && (hold_q == MAX_HOLD_C) && others_req_s);
        // Exactly one enable low is only legitimate while we are driving.
        err_s        = (state_q == ST_DRIVE) ? (bus.i_net_noe != 1'b0)
                                             : (bus.i_net_noe == 1'b0);
        err_d        = err_s ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);
    end

    // Next-state logic for the IDLE / DRIVE / TURNAROUND sequencer and its counters.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_d = ST_DRIVE;
                    owner_d = win_idx_s;
                    rr_d    = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + IDX_W'(1);
                    hold_d  = 15'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (release_s) begin
                    state_d = ST_TURN;
                    dead_d  = DEAD_C;
                end else begin
                    hold_d  = (hold_q == HOLD_SAT) ? hold_q : hold_q + 15'd1;
                end
            end
            ST_TURN: begin
                if (dead_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    dead_d  = 4'd0;
                end else begin
                    dead_d  = dead_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dead_d  = 4'd0;
            end
        endcase
    end

    // Enables and data lanes follow the next state so both switch on the same edge.
    always_comb begin
        noe_d  = ALL_HIGH;
        data_d = DATA_IDLE;
        if (state_d == ST_DRIVE) begin
            noe_d = ~(ONE_HOT0 << owner_d);
            data_d[owner_d*WIDTH +: WIDTH] = bus.i_data[owner_d*WIDTH +: WIDTH];
        end else begin
            noe_d = ALL_HIGH;
        end
    end

    // State registers with synchronous active-low reset; reset releases the bus immediately.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            hold_q  <= 15'd0;
            dead_q  <= 4'd0;
            noe_q   <= ALL_HIGH;
            data_q  <= DATA_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            dead_q  <= dead_d;
            noe_q   <= noe_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_noe  = noe_q;
    assign bus.o_gnt  = ~noe_q;
    assign bus.o_data = data_q;
    assign bus.o_busy = (state_q != ST_IDLE);
    assign bus.o_err  = err_q;
endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Directed bench: one arbiter without preemption, one with MAX_HOLD=4.
module tb_bus_drive_arbiter;
    logic clk;
    logic nrst;
    int   n_total;
    int   n_pass;
    int   n_fail;
    logic force0_en, force0_val, force4_en, force4_val;
    logic [1:0] exp_rr [13];

    bus_drive_arbiter_if #(.N_DRV(2), .WIDTH(8)) bif0 ();
    bus_drive_arbiter_if #(.N_DRV(2), .WIDTH(8)) bif4 ();

    bus_drive_arbiter #(.N_DRV(2), .WIDTH(8), .DEAD_CYCLES(1), .MAX_HOLD(0)) dut0 (
        .i_clk(clk), .i_nrst(nrst), .bus(bif0.slave));
    bus_drive_arbiter #(.N_DRV(2), .WIDTH(8), .DEAD_CYCLES(1), .MAX_HOLD(4)) dut4 (
        .i_clk(clk), .i_nrst(nrst), .bus(bif4.slave));

    // Resolved net: 0 only when exactly one enable is low.
    function automatic logic net_of(input logic [1:0] noe);
        logic [1:0] en;
        en = ~noe;
        return ($countones(en) == 1) ? 1'b0 : 1'b1;
    endfunction

    assign bif0.i_net_noe = force0_en ? force0_val : net_of(bif0.o_noe);
    assign bif4.i_net_noe = force4_en ? force4_val : net_of(bif4.o_noe);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        force0_en = 1'b0; force0_val = 1'b0; force4_en = 1'b0; force4_val = 1'b0;
        nrst = 1'b0;
        bif0.i_req = 2'b00; bif0.i_data = 16'h0000; bif0.i_err_clr = 1'b0;
        bif4.i_req = 2'b00; bif4.i_data = 16'h0000; bif4.i_err_clr = 1'b0;
        exp_rr = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                   2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

        // Reset then idle
        tick(); tick();
        chk("rst_noe",  32'(bif0.o_noe),  32'h3);
        chk("rst_gnt",  32'(bif0.o_gnt),  32'h0);
        chk("rst_data", 32'(bif0.o_data), 32'hFFFF);
        chk("rst_busy", 32'(bif0.o_busy), 32'h0);
        chk("rst_err",  32'(bif0.o_err),  32'h0);
        nrst = 1'b1;
        tick();
        chk("idle_noe", 32'(bif0.o_noe), 32'h3);
        chk("idle_err", 32'(bif0.o_err), 32'h0);

        // Single grant to driver 1
        bif0.i_req = 2'b10; bif0.i_data = 16'hA53C;
        tick();
        chk("g1_noe",  32'(bif0.o_noe),  32'h1);
        chk("g1_gnt",  32'(bif0.o_gnt),  32'h2);
        chk("g1_data", 32'(bif0.o_data), 32'hA5FF);
        chk("g1_busy", 32'(bif0.o_busy), 32'h1);
        bif0.i_data = 16'h5A3C;
        tick();
        chk("g1_data_upd", 32'(bif0.o_data), 32'h5AFF);
        // Drop req 1, raise req 0: exactly two all-high cycles between owners
        bif0.i_req = 2'b01;
        tick();
        chk("dead1_noe",  32'(bif0.o_noe),  32'h3);
        chk("dead1_data", 32'(bif0.o_data), 32'hFFFF);
        chk("dead1_busy", 32'(bif0.o_busy), 32'h1);
        tick();
        chk("dead2_noe",  32'(bif0.o_noe),  32'h3);
        chk("dead2_busy", 32'(bif0.o_busy), 32'h0);
        tick();
        chk("g0_noe",  32'(bif0.o_noe),  32'h2);
        chk("g0_data", 32'(bif0.o_data), 32'hFF3C);

        // No preemption with MAX_HOLD=0: driver 0 keeps the bus
        bif0.i_req = 2'b11;
        for (int i = 0; i < 20; i++) tick();
        chk("nopre_noe", 32'(bif0.o_noe), 32'h2);
        bif0.i_req = 2'b10;
        tick();
        chk("nopre_rel1", 32'(bif0.o_noe), 32'h3);
        tick();
        chk("nopre_rel2", 32'(bif0.o_noe), 32'h3);
        tick();
        chk("nopre_g1", 32'(bif0.o_noe), 32'h1);

        // Floating net during DRIVE sets the sticky error
        force0_en = 1'b1; force0_val = 1'b1;
        tick();
        chk("err_float", 32'(bif0.o_err), 32'h1);
        force0_en = 1'b0;
        tick();
        chk("err_sticky", 32'(bif0.o_err), 32'h1);
        bif0.i_err_clr = 1'b1;
        tick();
        bif0.i_err_clr = 1'b0;
        chk("err_clr", 32'(bif0.o_err), 32'h0);

        // Reset during DRIVE of driver 1
        chk("pre_rst_noe", 32'(bif0.o_noe), 32'h1);
        bif0.i_req = 2'b11;
        nrst = 1'b0;
        tick();
        chk("mrst_noe",  32'(bif0.o_noe),  32'h3);
        chk("mrst_busy", 32'(bif0.o_busy), 32'h0);
        chk("mrst_data", 32'(bif0.o_data), 32'hFFFF);
        nrst = 1'b1;
        tick();
        chk("mrst_rr0", 32'(bif0.o_noe), 32'h2);

        // Foreign driver in IDLE, then set-beats-clear
        bif0.i_req = 2'b00;
        tick(); tick(); tick();
        chk("back_idle", 32'(bif0.o_busy), 32'h0);
        chk("back_err",  32'(bif0.o_err),  32'h0);
        force0_en = 1'b1; force0_val = 1'b0;
        tick();
        chk("err_foreign", 32'(bif0.o_err), 32'h1);
        bif0.i_err_clr = 1'b1;
        tick();
        chk("err_set_wins", 32'(bif0.o_err), 32'h1);
        force0_en = 1'b0;
        tick();
        chk("err_clr2", 32'(bif0.o_err), 32'h0);
        bif0.i_err_clr = 1'b0;

        // Round-robin with MAX_HOLD=4 on the second instance
        bif4.i_req = 2'b11; bif4.i_data = 16'h2211;
        for (int i = 0; i < 13; i++) begin
            tick();
            chk($sformatf("rr_noe_%0d", i), 32'(bif4.o_noe), 32'(exp_rr[i]));
        end
        chk("rr_data0", 32'(bif4.o_data), 32'hFF11);
        // Owner alone is never preempted by the hold limit
        bif4.i_req = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        chk("solo_hold_noe", 32'(bif4.o_noe), 32'h2);
        chk("rr_err", 32'(bif4.o_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
